// File: rtl/clock_time_controller.sv
// clock_time_controller
//
// Sequencing and setting controller for a digital clock built from three
// wrap-around counters (seconds, minutes, hours).
//
// In RUN the 1 Hz tick becomes registered count-enable pulses with a carry
// chain. In the SET modes the controller walks hours -> minutes -> seconds
// on the mode button. The increment button loads a new value through the
// counters' synchronous preset path.
//
// Ports:
//   clock        system clock, rising edge
//   reset        asynchronous, active-low reset
//   tick         one-clock pulse at 1 Hz
//   btn_mode     debounced level, mode button
//   btn_inc      debounced level, increment button
//   sec_q        current seconds counter value
//   min_q        current minutes counter value
//   hour_q       current hours counter value
//   sec_en       seconds count-enable pulse
//   min_en       minutes count-enable pulse
//   hour_en      hours count-enable pulse
//   sec_preset   seconds preset strobe
//   min_preset   minutes preset strobe
//   hour_preset  hours preset strobe
//   preset_data  preset value; hours use the low HOUR_W bits
//   set_field    0=RUN, 1=hours, 2=minutes, 3=seconds (display blink select)

module clock_time_controller #(
  parameter int SEC_W      = 6,
  parameter int HOUR_W     = 5,
  parameter int SEC_LIMIT  = 59,
  parameter int MIN_LIMIT  = 59,
  parameter int HOUR_LIMIT = 23,
  parameter int TIMEOUT    = 30
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              tick,
  input  logic              btn_mode,
  input  logic              btn_inc,
  input  logic [SEC_W-1:0]  sec_q,
  input  logic [SEC_W-1:0]  min_q,
  input  logic [HOUR_W-1:0] hour_q,
  output logic              sec_en,
  output logic              min_en,
  output logic              hour_en,
  output logic              sec_preset,
  output logic              min_preset,
  output logic              hour_preset,
  output logic [SEC_W-1:0]  preset_data,
  output logic [1:0]        set_field
);

  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [SEC_W-1:0]  SEC_MAX  = SEC_W'(SEC_LIMIT);
  localparam logic [SEC_W-1:0]  MIN_MAX  = SEC_W'(MIN_LIMIT);
  localparam logic [HOUR_W-1:0] HOUR_MAX = HOUR_W'(HOUR_LIMIT);
  localparam logic [TW-1:0]     TO_LAST  = TW'(TIMEOUT - 1);

  // Encodings double as the set_field display code.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } state_t;

  state_t            state;
  logic              mode_prev;
  logic              inc_prev;
  logic              first_s;
  logic [TW-1:0]     tcnt;

  logic              mode_edge;
  logic              inc_edge;
  logic              sec_wrap;
  logic              min_wrap;
  logic [SEC_W-1:0]  sec_next;
  logic [SEC_W-1:0]  min_next;
  logic [HOUR_W-1:0] hour_next;

  // Rising-edge detection; a mode edge suppresses a simultaneous inc edge.
  // Next-value arithmetic is done at field width; anything at or above the
  // limit wraps to 0.
  always_comb begin
    mode_edge = btn_mode & ~mode_prev;
    inc_edge  = btn_inc & ~inc_prev & ~mode_edge;
    sec_wrap  = (sec_q == SEC_MAX);
    min_wrap  = (min_q == MIN_MAX);
    sec_next  = (sec_q  >= SEC_MAX)  ? '0 : sec_q  + SEC_W'(1);
    min_next  = (min_q  >= MIN_MAX)  ? '0 : min_q  + SEC_W'(1);
    hour_next = (hour_q >= HOUR_MAX) ? '0 : hour_q + HOUR_W'(1);
  end

  // set_field is written together with state, so it shows the new mode in
  // the cycle after the triggering edge. preset_data is only written when a
  // strobe is issued and holds otherwise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      mode_prev   <= 1'b1;
      inc_prev    <= 1'b1;
      first_s     <= 1'b0;
      tcnt        <= '0;
      sec_en      <= 1'b0;
      min_en      <= 1'b0;
      hour_en     <= 1'b0;
      sec_preset  <= 1'b0;
      min_preset  <= 1'b0;
      hour_preset <= 1'b0;
      preset_data <= '0;
      set_field   <= 2'd0;
    end else begin
      mode_prev   <= btn_mode;
      inc_prev    <= btn_inc;
      sec_en      <= 1'b0;
      min_en      <= 1'b0;
      hour_en     <= 1'b0;
      sec_preset  <= 1'b0;
      min_preset  <= 1'b0;
      hour_preset <= 1'b0;

      case (state)
        RUN: begin
          if (mode_edge) begin
            state     <= SET_H;
            set_field <= SET_H;
            tcnt      <= '0;
          end
          if (tick) begin
            sec_en  <= 1'b1;
            min_en  <= sec_wrap;
            hour_en <= sec_wrap & min_wrap;
          end
        end

        default: begin
          if (mode_edge) begin
            tcnt <= '0;
            case (state)
              SET_H: begin
                state     <= SET_M;
                set_field <= SET_M;
              end
              SET_M: begin
                state     <= SET_S;
                set_field <= SET_S;
                // The first inc in SET_S zeroes the seconds.
                first_s   <= 1'b1;
              end
              default: begin
                state     <= RUN;
                set_field <= RUN;
                first_s   <= 1'b0;
              end
            endcase
          end else if (inc_edge) begin
            tcnt <= '0;
            case (state)
              SET_H: begin
                hour_preset <= 1'b1;
                preset_data <= SEC_W'(hour_next);
              end
              SET_M: begin
                min_preset  <= 1'b1;
                preset_data <= min_next;
              end
              default: begin
                sec_preset  <= 1'b1;
                preset_data <= first_s ? '0 : sec_next;
                first_s     <= 1'b0;
              end
            endcase
          end else if (tick) begin
            // Ticks are not counted towards the time while setting; they
            // only age the inactivity timeout.
            if (tcnt >= TO_LAST) begin
              state     <= RUN;
              set_field <= RUN;
              tcnt      <= '0;
              first_s   <= 1'b0;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_time_controller.sv
// tb_clock_time_controller
//
// Directed bench for clock_time_controller with TIMEOUT shortened to 3.
// Each step drives inputs at the falling edge and samples 1 time unit
// after the following rising edge. The pulse vector is
// {sec_en, min_en, hour_en, sec_preset, min_preset, hour_preset}.

module tb_clock_time_controller;

  logic       clock;
  logic       reset;
  logic       tick;
  logic       btn_mode;
  logic       btn_inc;
  logic [5:0] sec_q;
  logic [5:0] min_q;
  logic [4:0] hour_q;
  logic       sec_en;
  logic       min_en;
  logic       hour_en;
  logic       sec_preset;
  logic       min_preset;
  logic       hour_preset;
  logic [5:0] preset_data;
  logic [1:0] set_field;

  int passCount  = 0;
  int checkCount = 0;

  clock_time_controller #(
    .SEC_W(6), .HOUR_W(5), .SEC_LIMIT(59), .MIN_LIMIT(59),
    .HOUR_LIMIT(23), .TIMEOUT(3)
  ) dut (
    .clock(clock), .reset(reset), .tick(tick),
    .btn_mode(btn_mode), .btn_inc(btn_inc),
    .sec_q(sec_q), .min_q(min_q), .hour_q(hour_q),
    .sec_en(sec_en), .min_en(min_en), .hour_en(hour_en),
    .sec_preset(sec_preset), .min_preset(min_preset),
    .hour_preset(hour_preset),
    .preset_data(preset_data), .set_field(set_field)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [5:0] pulses();
    return {sec_en, min_en, hour_en, sec_preset, min_preset, hour_preset};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic t, input logic m, input logic i);
    @(negedge clock);
    tick     = t;
    btn_mode = m;
    btn_inc  = i;
    @(posedge clock);
    #1;
  endtask

  // Idle cycle that releases both buttons.
  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset    = 1'b0;
    tick     = 1'b0;
    btn_mode = 1'b1;
    btn_inc  = 1'b0;
    sec_q    = 6'd0;
    min_q    = 6'd0;
    hour_q   = 5'd0;

    #23;
    checkOutput("reset_pulses", 32'(pulses()), 32'h0);
    checkOutput("reset_field", 32'(set_field), 32'd0);
    checkOutput("reset_data", 32'(preset_data), 32'd0);

    // Release reset with mode held: no edge, stay in RUN.
    @(negedge clock);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("held_mode_field", 32'(set_field), 32'd0);
    checkOutput("held_mode_pulses", 32'(pulses()), 32'h0);
    idle();

    // RUN carry chain.
    sec_q = 6'd58; min_q = 6'd59; hour_q = 5'd23;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("run_tick58", 32'(pulses()), 32'b100000);
    idle();
    checkOutput("run_pulse_one_cycle", 32'(pulses()), 32'h0);
    sec_q = 6'd59;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("run_full_carry", 32'(pulses()), 32'b111000);
    idle();
    checkOutput("run_carry_one_cycle", 32'(pulses()), 32'h0);
    // Inc is ignored in RUN.
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("run_inc_ignored", 32'(pulses()), 32'h0);
    idle();

    // SET_H.
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("enter_set_h", 32'(set_field), 32'd1);
    idle();
    hour_q = 5'd23;
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("hour_wrap_strobe", 32'(pulses()), 32'b000001);
    checkOutput("hour_wrap_data", 32'(preset_data), 32'd0);
    idle();
    hour_q = 5'd5;
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("hour_inc_strobe", 32'(pulses()), 32'b000001);
    checkOutput("hour_inc_data", 32'(preset_data), 32'd6);
    idle();
    checkOutput("hour_data_hold", 32'(preset_data), 32'd6);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("set_h_tick_frozen", 32'(pulses()), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("set_h_tick_frozen2", 32'(pulses()), 32'h0);
    checkOutput("set_h_still", 32'(set_field), 32'd1);

    // SET_M, then SET_S.
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("enter_set_m", 32'(set_field), 32'd2);
    idle();
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("enter_set_s", 32'(set_field), 32'd3);
    idle();
    sec_q = 6'd42;
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("sec_first_strobe", 32'(pulses()), 32'b000100);
    checkOutput("sec_first_data", 32'(preset_data), 32'd0);
    idle();
    sec_q = 6'd0;
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("sec_inc_data", 32'(preset_data), 32'd1);
    idle();

    // Mode out of SET_S coincident with a tick: no catch-up enable.
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("exit_s_field", 32'(set_field), 32'd0);
    checkOutput("exit_s_no_enable", 32'(pulses()), 32'h0);
    idle();
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("resume_tick", 32'(pulses()), 32'b100000);
    idle();

    // Timeout out of SET_M after three ticks.
    applyStimulus(1'b0, 1'b1, 1'b0);
    idle();
    applyStimulus(1'b0, 1'b1, 1'b0);
    idle();
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("timeout_tick2_field", 32'(set_field), 32'd2);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("timeout_field", 32'(set_field), 32'd0);
    checkOutput("timeout_no_enable", 32'(pulses()), 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("after_timeout_tick", 32'(pulses()), 32'b100000);
    idle();

    // Inc edge on the third tick wins over the timeout.
    applyStimulus(1'b0, 1'b1, 1'b0);
    idle();
    applyStimulus(1'b0, 1'b1, 1'b0);
    idle();
    min_q = 6'd59;
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("inc_beats_timeout_strobe", 32'(pulses()), 32'b000010);
    checkOutput("inc_beats_timeout_data", 32'(preset_data), 32'd0);
    checkOutput("inc_beats_timeout_field", 32'(set_field), 32'd2);
    idle();
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("timeout_counter_cleared", 32'(set_field), 32'd2);
    idle();

    // Mode wins over a simultaneous inc: SET_M -> SET_S, no preset.
    btn_inc = 1'b0;
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("mode_beats_inc_field", 32'(set_field), 32'd3);
    checkOutput("mode_beats_inc_pulses", 32'(pulses()), 32'h0);
    idle();
    applyStimulus(1'b0, 1'b1, 1'b0);
    idle();
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("back_in_set_h", 32'(set_field), 32'd1);
    idle();

    // Asynchronous reset in SET_H together with an inc edge.
    @(negedge clock);
    reset   = 1'b0;
    btn_inc = 1'b1;
    #1;
    checkOutput("async_reset_field", 32'(set_field), 32'd0);
    @(posedge clock);
    #1;
    checkOutput("reset_inc_no_strobe", 32'(pulses()), 32'h0);
    checkOutput("reset_data_cleared", 32'(preset_data), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("post_reset_run", 32'(set_field), 32'd0);
    checkOutput("post_reset_pulses", 32'(pulses()), 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
